// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with its own tick prescaler, start/stop/load
// commands, optional auto-reload and a one-cycle expiry pulse.
module bcd_timer #(
   parameter int                  DIGITS   = 4,
   parameter logic [4*DIGITS-1:0] MODULI   = 16'h9999,
   parameter int                  TICK_DIV = 5_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_value,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_dir,
   input  logic                  i_autoreload,
   output logic [4*DIGITS-1:0]   o_value,
   output logic                  o_running,
   output logic                  o_tick,
   output logic                  o_expired,
   output logic [1:0]            dbg_state
);

   localparam int             W          = 4 * DIGITS;
   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    reload;
   logic [PW-1:0]   presc;

   logic [W-1:0]    terminal;
   logic [W-1:0]    stepped;
   logic [W-1:0]    load_clamped;
   logic            at_terminal;
   logic            step_hits;
   logic            presc_wrap;

   // Any nibble above its modulus is pulled down to it, so the counter never
   // holds a digit it cannot step through.
   function automatic logic [W-1:0] clamp_value(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] > MODULI[4*d +: 4])
            r[4*d +: 4] = MODULI[4*d +: 4];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] step_value(input logic [W-1:0] v, input logic down);
      logic [W-1:0] r;
      logic         carry;
      logic [3:0]   nib;
      logic [3:0]   lim;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         nib = v[4*d +: 4];
         lim = MODULI[4*d +: 4];
         if (carry) begin
            if (down) begin
               if (nib == 4'd0) begin
                  r[4*d +: 4] = lim;
               end else begin
                  r[4*d +: 4] = nib - 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (nib == lim) begin
                  r[4*d +: 4] = 4'd0;
               end else begin
                  r[4*d +: 4] = nib + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign terminal     = i_dir ? '0 : MODULI;
   assign at_terminal  = (o_value == terminal);
   // A step taken while already at terminal holds there instead of wrapping.
   assign stepped      = at_terminal ? o_value : step_value(o_value, i_dir);
   assign step_hits    = (stepped == terminal);
   assign presc_wrap   = (presc == PRESC_LAST);
   assign load_clamped = clamp_value(i_load_value);
   assign dbg_state    = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         o_value   <= '0;
         reload    <= '0;
         presc     <= '0;
         o_running <= 1'b0;
         o_tick    <= 1'b0;
         o_expired <= 1'b0;
      end else begin
         o_tick    <= 1'b0;
         o_expired <= 1'b0;
         if (i_load) begin
            o_value   <= load_clamped;
            reload    <= load_clamped;
            presc     <= '0;
            state     <= IDLE;
            o_running <= 1'b0;
         end else if (i_stop) begin
            // Stop outranks start even outside RUN; the prescaler keeps its
            // partial period for a later resume.
            if (state == RUN) begin
               state     <= IDLE;
               o_running <= 1'b0;
            end
         end else if (i_start && (state != RUN)) begin
            if (!at_terminal) begin
               state     <= RUN;
               o_running <= 1'b1;
            end else if (i_autoreload) begin
               o_value   <= reload;
               presc     <= '0;
               state     <= RUN;
               o_running <= 1'b1;
            end
         end else if (state == RUN) begin
            if (presc_wrap) begin
               presc  <= '0;
               o_tick <= 1'b1;
               if (step_hits) begin
                  o_expired <= 1'b1;
                  if (i_autoreload) begin
                     o_value <= reload;
                  end else begin
                     o_value   <= stepped;
                     state     <= DONE;
                     o_running <= 1'b0;
                  end
               end else begin
                  o_value <= stepped;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer with two mm:ss-style digits (MODULI 8'h59)
// and a four-cycle prescaler; expected values are worked out by hand.
module tb_bcd_timer;

   localparam int TD = 4;

   logic       clk;
   logic       rst;
   logic       i_load;
   logic [7:0] i_load_value;
   logic       i_start;
   logic       i_stop;
   logic       i_dir;
   logic       i_autoreload;
   logic [7:0] o_value;
   logic       o_running;
   logic       o_tick;
   logic       o_expired;
   logic [1:0] dbg_state;

   int tests  = 0;
   int failed = 0;

   bcd_timer #(
      .DIGITS   (2),
      .MODULI   (8'h59),
      .TICK_DIV (TD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_load       (i_load),
      .i_load_value (i_load_value),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_dir        (i_dir),
      .i_autoreload (i_autoreload),
      .o_value      (o_value),
      .o_running    (o_running),
      .o_tick       (o_tick),
      .o_expired    (o_expired),
      .dbg_state    (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] v);
      i_load       = 1'b1;
      i_load_value = v;
      cyc();
      i_load       = 1'b0;
   endtask

   // TD-1 quiet cycles, then the step edge with its new value and expiry flag.
   task automatic run_step(input string tag, input logic [7:0] exp_val, input logic exp_exp);
      for (int i = 0; i < TD - 1; i++) begin
         cyc();
         chk({tag, "_quiet_tick"}, 8'(o_tick), 8'd0);
      end
      cyc();
      chk({tag, "_tick"}, 8'(o_tick), 8'd1);
      chk({tag, "_value"}, o_value, exp_val);
      chk({tag, "_expired"}, 8'(o_expired), 8'(exp_exp));
   endtask

   initial begin
      rst          = 1'b1;
      i_load       = 1'b0;
      i_load_value = 8'h00;
      i_start      = 1'b0;
      i_stop       = 1'b0;
      i_dir        = 1'b1;
      i_autoreload = 1'b0;
      cyc();
      cyc();
      chk("rst_value", o_value, 8'h00);
      chk("rst_running", 8'(o_running), 8'd0);
      chk("rst_tick", 8'(o_tick), 8'd0);
      chk("rst_expired", 8'(o_expired), 8'd0);
      chk("rst_state", 8'(dbg_state), 8'd0);
      rst = 1'b0;
      cyc();

      // Countdown 03 -> 00 ending in DONE.
      load(8'h03);
      chk("t1_load_value", o_value, 8'h03);
      chk("t1_load_state", 8'(dbg_state), 8'd0);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("t1_running", 8'(o_running), 8'd1);
      run_step("t1_s1", 8'h02, 1'b0);
      run_step("t1_s2", 8'h01, 1'b0);
      run_step("t1_s3", 8'h00, 1'b1);
      chk("t1_done_running", 8'(o_running), 8'd0);
      chk("t1_done_state", 8'(dbg_state), 8'd2);

      // Start while sitting at terminal without auto-reload does nothing.
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("t6_term_start_state", 8'(dbg_state), 8'd2);
      chk("t6_term_start_running", 8'(o_running), 8'd0);
      chk("t6_term_start_value", o_value, 8'h00);

      // Digit borrow: 10 -> 09.
      load(8'h10);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      run_step("t2_borrow", 8'h09, 1'b0);

      // Count up from 00 to the modulus 59; expiry on the step that lands on 59.
      load(8'h00);
      i_dir   = 1'b0;
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      for (int k = 1; k <= 59; k++) begin
         run_step($sformatf("t2_up%0d", k), {4'(k / 10), 4'(k % 10)}, (k == 59));
      end
      chk("t2_up_state", 8'(dbg_state), 8'd2);
      chk("t2_up_running", 8'(o_running), 8'd0);

      // Auto-reload: 03, 02, 01, then reload to 03 with expiry, 02.
      i_dir        = 1'b1;
      i_autoreload = 1'b1;
      load(8'h03);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      run_step("t3_s1", 8'h02, 1'b0);
      run_step("t3_s2", 8'h01, 1'b0);
      run_step("t3_s3", 8'h03, 1'b1);
      chk("t3_running_after_reload", 8'(o_running), 8'd1);
      run_step("t3_s4", 8'h02, 1'b0);
      chk("t3_running", 8'(o_running), 8'd1);

      // Pause keeps the partial prescaler period.
      i_stop = 1'b1;
      cyc();
      i_stop       = 1'b0;
      i_autoreload = 1'b0;
      load(8'h03);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      cyc();
      cyc();
      chk("t4_pre_stop_tick", 8'(o_tick), 8'd0);
      i_stop = 1'b1;
      cyc();
      i_stop = 1'b0;
      chk("t4_paused_state", 8'(dbg_state), 8'd0);
      repeat (10) cyc();
      chk("t4_paused_value", o_value, 8'h03);
      chk("t4_paused_tick", 8'(o_tick), 8'd0);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("t4_resume_running", 8'(o_running), 8'd1);
      cyc();
      chk("t4_resume_c1_tick", 8'(o_tick), 8'd0);
      cyc();
      chk("t4_resume_c2_tick", 8'(o_tick), 8'd1);
      chk("t4_resume_c2_value", o_value, 8'h02);

      // Start and stop together in IDLE: stop wins.
      i_stop = 1'b1;
      cyc();
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      i_stop  = 1'b0;
      chk("t4_startstop_state", 8'(dbg_state), 8'd0);
      chk("t4_startstop_running", 8'(o_running), 8'd0);
      repeat (6) cyc();
      chk("t4_startstop_value", o_value, 8'h02);

      // Clamp on load, then a load that collides with a step edge.
      load(8'h7A);
      chk("t5_clamp_value", o_value, 8'h59);
      chk("t5_clamp_state", 8'(dbg_state), 8'd0);
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("t5_pre_tick", 8'(o_tick), 8'd0);
      i_load       = 1'b1;
      i_load_value = 8'h25;
      cyc();
      i_load = 1'b0;
      chk("t5_collide_value", o_value, 8'h25);
      chk("t5_collide_tick", 8'(o_tick), 8'd0);
      chk("t5_collide_expired", 8'(o_expired), 8'd0);
      chk("t5_collide_state", 8'(dbg_state), 8'd0);
      chk("t5_collide_running", 8'(o_running), 8'd0);

      // Asynchronous reset between clock edges.
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      cyc();
      cyc();
      chk("t6_pre_rst_running", 8'(o_running), 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_value", o_value, 8'h00);
      chk("t6_async_running", 8'(o_running), 8'd0);
      chk("t6_async_state", 8'(dbg_state), 8'd0);
      chk("t6_async_tick", 8'(o_tick), 8'd0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("t6_post_rst_value", o_value, 8'h00);

      // Reload register is zero after reset: auto-reload start at terminal
      // reloads 00 and then expires on every step.
      i_autoreload = 1'b1;
      i_start      = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("t6_reload_running", 8'(o_running), 8'd1);
      run_step("t6_zero_s1", 8'h00, 1'b1);
      run_step("t6_zero_s2", 8'h00, 1'b1);
      chk("t6_zero_running", 8'(o_running), 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
